// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - fetch-facing decode stage with one-slot output register; optional macro DECODE_PERF_EN adds perf counters
module decode_unit #(
    parameter int         PC_W    = 12,
    parameter int         INSTR_W = 16,
    parameter logic [3:0] OP_LDI  = 4'h1,
    parameter logic [3:0] OP_HALT = 4'hE,
    parameter logic [3:0] OP_JMP  = 4'hF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instruction,
    output logic               en_pc,
    output logic               en_new_pc,
    output logic [PC_W-1:0]    new_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [3:0]         out_rd,
    output logic [3:0]         out_rs1,
    output logic [3:0]         out_rs2,
    output logic [11:0]        out_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic               halted
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0]        perf_issued,
    output logic [15:0]        perf_stall
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            live_q;       // low only in the first cycle after reset so every output starts at 0
    logic [PC_W-1:0] fpc_q;        // mirror of the fetch unit's pc
    logic [PC_W-1:0] ipc_q;        // address of the word currently on instruction
    logic            inst_valid_q;

    logic            consume;
    logic            jump;
    logic            fwd;
    logic            stall;
    logic [11:0]     imm_d;
    logic [3:0]      opc;

    assign opc    = instruction[15:12];
    assign halted = (state_q == ST_HALTED);

    // Next state, fetch controls and decoded immediate
    always_comb begin
        state_d   = state_q;
        consume   = live_q & inst_valid_q & (~out_valid | out_ready) & (state_q == ST_RUN);
        jump      = consume & (opc == OP_JMP);
        fwd       = consume & ~jump;
        stall     = inst_valid_q & ~consume & (state_q == ST_RUN);
        en_new_pc = jump;
        new_pc    = jump ? instruction[PC_W-1:0] : '0;
        en_pc     = live_q & (state_q == ST_RUN) & (~inst_valid_q | consume) & ~jump;
        if (fwd && (opc == OP_HALT)) begin
            state_d = ST_HALTED;
        end
        case (opc)
            OP_LDI:  imm_d = {4'h0, instruction[7:0]};
            OP_JMP:  imm_d = instruction[11:0];
            default: imm_d = 12'h000;
        endcase
    end

    // State register, fetch pc mirror and instruction-valid tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            live_q       <= 1'b0;
            fpc_q        <= '0;
            ipc_q        <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (en_pc) begin
                fpc_q <= fpc_q + PC_W'(1);
                ipc_q <= fpc_q;
            end else if (en_new_pc) begin
                fpc_q <= new_pc;
            end
            // The word latched on a redirect cycle is stale, so it never becomes valid
            if (en_pc) begin
                inst_valid_q <= 1'b1;
            end else if (consume) begin
                inst_valid_q <= 1'b0;
            end
        end
    end

    // Single registered output slot; fields hold while execute back-pressures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_opcode <= 4'h0;
            out_rd     <= 4'h0;
            out_rs1    <= 4'h0;
            out_rs2    <= 4'h0;
            out_imm    <= 12'h000;
            out_pc     <= '0;
        end else if (fwd) begin
            out_valid  <= 1'b1;
            out_opcode <= opc;
            out_rd     <= instruction[11:8];
            out_rs1    <= instruction[7:4];
            out_rs2    <= instruction[3:0];
            out_imm    <= imm_d;
            out_pc     <= ipc_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_PERF_EN
    // Saturating issue and stall counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued <= 16'h0000;
            perf_stall  <= 16'h0000;
        end else begin
            if (fwd && (perf_issued != 16'hFFFF)) begin
                perf_issued <= perf_issued + 16'h0001;
            end
            if (stall && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - randomized self-checking bench for decode_unit against a program-walk model
module tb_decode_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] instruction;
    logic        en_pc;
    logic        en_new_pc;
    logic [11:0] new_pc;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [11:0] out_imm;
    logic [11:0] out_pc;
    logic        halted;
`ifdef DECODE_PERF_EN
    logic [15:0] perf_issued;
    logic [15:0] perf_stall;
`endif

    always #5 clk = ~clk;

    decode_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .en_pc       (en_pc),
        .en_new_pc   (en_new_pc),
        .new_pc      (new_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .halted      (halted)
`ifdef DECODE_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    // Instruction memory and fetch unit: registered word, advances on en_pc, redirects on en_new_pc
    logic [15:0] mem [0:4095];
    logic [11:0] f_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_pc        <= 12'h000;
            instruction <= 16'h0000;
        end else if (en_pc) begin
            instruction <= mem[f_pc];
            f_pc        <= f_pc + 12'h001;
        end else if (en_new_pc) begin
            instruction <= mem[f_pc];
            f_pc        <= new_pc;
        end
    end

    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [11:0] imm;
        logic [11:0] pc;
    } op_t;

    op_t         exp_q[$];
    logic [11:0] jmp_q[$];
    bit          prog_halts;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 0;
    int          acc_cnt;
    int          jmp_cnt;
    int          en_pc_in_stall;
    int          ready_mode = 0;
    int          stall_left;
    bit          stall_started;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-level model: walk memory from pc 0, jumps redirect, every other op is issued in order
    task automatic build_model(input int limit);
        logic [11:0] pc;
        logic [15:0] w;
        op_t         o;
        pc = 12'h000;
        exp_q.delete();
        jmp_q.delete();
        prog_halts = 0;
        for (int s = 0; s < limit; s++) begin
            w = mem[pc];
            if (w[15:12] == 4'hF) begin
                jmp_q.push_back(w[11:0]);
                pc = w[11:0];
            end else begin
                o.opc = w[15:12];
                o.rd  = w[11:8];
                o.rs1 = w[7:4];
                o.rs2 = w[3:0];
                o.imm = (w[15:12] == 4'h1) ? {4'h0, w[7:0]} : 12'h000;
                o.pc  = pc;
                exp_q.push_back(o);
                if (w[15:12] == 4'hE) begin
                    prog_halts = 1;
                    break;
                end
                pc = pc + 12'h001;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    endtask

    // Random straight-line program with jumps to unvisited addresses, ending in HALT
    task automatic gen_prog(input int len);
        bit          used [4096];
        logic [11:0] pc;
        logic [11:0] t;
        logic [3:0]  opc;
        fill_random();
        for (int i = 0; i < 4096; i++) used[i] = 0;
        pc = 12'h000;
        for (int s = 0; s < len; s++) begin
            used[pc] = 1;
            if (s == len - 1) begin
                mem[pc] = {4'hE, 12'($urandom)};
                break;
            end
            if ($urandom_range(0, 7) == 0 || used[pc + 12'h001]) begin
                do t = 12'($urandom); while (used[t]);
                mem[pc] = {4'hF, t};
                pc = t;
            end else begin
                opc = 4'($urandom_range(0, 13));
                mem[pc] = {opc, 12'($urandom)};
                pc = pc + 12'h001;
            end
        end
    endtask

    // Compare process: acceptances, hold stability, redirects, halted quiescence
    initial begin
        op_t o;
        op_t held;
        bit  hold_prev;
        hold_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                hold_prev = 0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_fields", 64'({out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc}), 64'(held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() > 0) begin
                        o = exp_q.pop_front();
                        check("op_fields", 64'({out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc}), 64'(o));
                        acc_cnt++;
                    end else if (prog_halts) begin
                        check("unexpected_op", 64'(out_pc), 64'hFFFF_FFFF);
                    end
                end
                hold_prev = out_valid && !out_ready;
                held = {out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc};
                if (out_valid && !out_ready && en_pc) en_pc_in_stall++;
                check("en_excl", 64'(en_pc & en_new_pc), 64'd0);
                if (en_new_pc) begin
                    jmp_cnt++;
                    if (jmp_q.size() > 0) check("new_pc", 64'(new_pc), 64'(jmp_q.pop_front()));
                    else if (prog_halts) check("unexpected_jump", 64'(new_pc), 64'hFFFF_FFFF);
                end
                if (halted) check("halted_quiet", 64'({en_pc, en_new_pc}), 64'd0);
            end
        end
    end

    // Ready driver, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 9) < 7);
                default: begin
                    if (!stall_started && out_valid) begin
                        stall_started = 1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic do_reset(input int mode);
        chk_en = 0;
        ready_mode = mode;
        stall_started = 0;
        stall_left = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({en_pc, en_new_pc, new_pc, out_valid, out_opcode, out_rd,
                                    out_rs1, out_rs2, out_imm, out_pc, halted}), 64'd0);
        reset_n = 1'b1;
        acc_cnt = 0;
        jmp_cnt = 0;
        en_pc_in_stall = 0;
        chk_en = 1;
        @(posedge clk);
        #2;
        check("en_pc_cycle1", 64'(en_pc), 64'd1);
    endtask

    task automatic run_prog(input int mode, input string tag);
        bit done;
        do_reset(mode);
        done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && (!prog_halts || (halted && !out_valid))) begin
                done = 1;
                break;
            end
        end
        if (!done) check({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
        repeat (6) @(negedge clk);
        #1;
        chk_en = 0;
    endtask

    initial begin
        bit seen;

        // Basic three-op program
        fill_random();
        mem[0] = 16'h1105; mem[1] = 16'h2312; mem[2] = 16'hE000;
        build_model(50);
        check("model_len", 64'(exp_q.size()), 64'd3);
        check("model_op0", 64'(exp_q[0]), 64'({4'h1, 4'h1, 4'h0, 4'h5, 12'h005, 12'h000}));
        check("model_op1", 64'(exp_q[1]), 64'({4'h2, 4'h3, 4'h1, 4'h2, 12'h000, 12'h001}));
        check("model_op2_pc", 64'(exp_q[2].pc), 64'h002);
        run_prog(0, "basic");
        check("basic_accepted", 64'(acc_cnt), 64'd3);
        check("basic_halted", 64'(halted), 64'd1);
        check("basic_en_pc_after", 64'(en_pc), 64'd0);

        // Same program with a 5-cycle back-pressure after the first op
        build_model(50);
        run_prog(2, "stall");
        check("stall_accepted", 64'(acc_cnt), 64'd3);
        check("stall_en_pc_low", 64'(en_pc_in_stall), 64'd0);
`ifdef DECODE_PERF_EN
        check("perf_issued", 64'(perf_issued), 64'd3);
        check("perf_stall", 64'(perf_stall), 64'd5);
`endif

        // Jump with a stale word at address 1
        fill_random();
        mem[0] = 16'hF010; mem[1] = 16'h3ABC; mem[12'h010] = 16'h1107; mem[12'h011] = 16'hE000;
        build_model(50);
        check("model_jmp_target", 64'(jmp_q[0]), 64'h010);
        check("model_jmp_op0", 64'({exp_q[0].pc, exp_q[0].imm}), 64'({12'h010, 12'h007}));
        run_prog(0, "jump");
        check("jump_count", 64'(jmp_cnt), 64'd1);
        check("jump_accepted", 64'(acc_cnt), 64'd2);

        // Jump to the top of the address space and wrap back to 0
        fill_random();
        mem[0] = 16'h2000; mem[1] = 16'hFFFF; mem[12'hFFF] = 16'h1101;
        build_model(7);
        check("model_wrap_pc1", 64'(exp_q[1].pc), 64'hFFF);
        check("model_wrap_pc2", 64'(exp_q[2].pc), 64'h000);
        run_prog(1, "wrap");
        check("wrap_accepted", 64'(acc_cnt), 64'd5);

        // Asynchronous reset while an op is presented, then restart from pc 0
        fill_random();
        mem[0] = 16'h1105; mem[1] = 16'h2312; mem[2] = 16'hE000;
        build_model(50);
        do_reset(1);
        seen = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check("midreset_seen_valid", 64'(seen), 64'd1);
        chk_en = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", 64'({en_pc, en_new_pc, new_pc, out_valid, out_opcode, out_rd,
                                       out_rs1, out_rs2, out_imm, out_pc, halted}), 64'd0);
        build_model(50);
        run_prog(1, "restart");
        check("restart_accepted", 64'(acc_cnt), 64'd3);

        // Randomized programs with random back-pressure
        for (int p = 0; p < 25; p++) begin
            gen_prog(int'($urandom_range(10, 60)));
            build_model(200);
            run_prog(1, "random");
            check("random_halted", 64'(halted), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_unit.md
Name: decode_unit

Overview:
Decode stage directly downstream of the instruction fetch unit.
- Drives the fetch unit's en_pc / en_new_pc / new_pc controls.
- Tracks which fetched word is valid and which is stale, and splits the 16-bit instruction into fields with the PC that fetched it.
- Presents decoded ops to execute through a valid/ready handshake with a single registered output slot.
- Resolves unconditional jumps and HALT locally.

Parameters:
PC_W, 12, fetch address width
INSTR_W, 16, instruction width
OP_LDI, 4'h1, load-immediate opcode (imm8 in [7:0])
OP_HALT, 4'hE, halt opcode
OP_JMP, 4'hF, absolute jump opcode (target in [11:0])

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
instruction  in  16  registered fetch output; updates one cycle after en_pc or en_new_pc
en_pc  out  1  fetch advance request
en_new_pc  out  1  fetch redirect request
new_pc  out  12  redirect target
out_valid  out  1  decoded op valid
out_ready  in  1  execute accepts op
out_opcode  out  4  instruction[15:12]
out_rd  out  4  instruction[11:8]
out_rs1  out  4  instruction[7:4]
out_rs2  out  4  instruction[3:0]
out_imm  out  12  immediate (see Behaviour)
out_pc  out  12  address of decoded instruction
halted  out  1  HALT has been issued

Behaviour:
- Reset values: all outputs 0; internal fpc=0, inst_valid=0, state=RUN.
- fpc mirrors the fetch pc: +1 when en_pc, <=new_pc when en_new_pc.
- ipc captures fpc whenever en_pc is high; it is the address of the word arriving next cycle.
- inst_valid (next): en_pc -> 1; else consume -> 0; else hold.
  - Consequence: the stale word latched on a redirect cycle is never valid.
- consume = inst_valid & (~out_valid | out_ready) & state==RUN.
- en_pc = state==RUN & (~inst_valid | consume) & ~en_new_pc.
  - On a back-to-back stream this gives one instruction per cycle.
- Stall: with en_pc low, the fetch register holds its word, so no skid buffer is needed.
- Jump (opcode OP_JMP while consuming):
  - en_new_pc=1 and new_pc=instruction[11:0], combinationally, in the same cycle.
  - en_pc=0 in that cycle.
  - The JMP is not forwarded.
  - The first target word is valid 2 cycles later.
- Forwarding (all other opcodes while consuming): the output register loads the fields, out_pc=ipc, and out_valid=1.
- out_imm:
  - OP_LDI: {4'h0, instruction[7:0]}
  - OP_JMP: instruction[11:0]
  - all other opcodes: 12'h0
- Output handshake: out_valid clears on out_valid & out_ready with no new consume; fields are stable while out_valid & ~out_ready.
- HALT:
  - Forwarded like any other op.
  - state -> HALTED; halted=1; en_pc and en_new_pc stay 0 until reset.
  - A pending output still completes its handshake.
- fpc and new_pc wrap modulo 2^12 (12'hFFF+1 = 0).
- Reset mid-operation: async clear of all state; any in-flight instruction and output are dropped.

Optional Feature:
Macro DECODE_PERF_EN.
- Defined: adds ports perf_issued[15:0] (+1 per forwarded op) and perf_stall[15:0] (+1 per cycle with inst_valid & ~consume & state==RUN).
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory 0:1105, 1:2312, 2:E000, out_ready=1 -> en_pc high at cycle 1; out_valid sequence LDI (rd=1, imm=0x005, pc=0), then op 2 (rd=3, rs1=1, rs2=2, pc=1), then HALT (pc=2); halted=1; en_pc low afterwards.
- Same program with out_ready=0 for 5 cycles after the first op -> out fields stable; en_pc low during the stall; no instruction lost or duplicated; LDI pc=0 accepted once.
- Memory 0:F010, 0x010:1107, 0x011:E000 -> en_new_pc=1 with new_pc=0x010 once; the stale word from address 1 is never output; next op is pc=0x010, imm=0x007.
- Jump to 12'hFFF holding 1101, with 0x000 reached by wrap -> ops at pc=0xFFF then pc=0x000.
- Assert reset_n=0 mid-stream while out_valid=1 -> outputs zero immediately; after release, decode restarts from pc=0.
- DECODE_PERF_EN: 3 ops issued with a 5-cycle stall -> perf_issued=3, perf_stall=5.
